counter_monitor: RTL and testbench

- Receive-side checker for the team's T-flip-flop ripple counter: samples the counter's Q outputs (Q1 = bit 0 … Q3 = bit 2) on an independent, faster system clock.
- Synchronises and debounces the rippling bits, reconstructs the count, and verifies that every accepted change is a +1 step modulo 2^WIDTH.
- Reports lock status, wrap events and sequence errors; sits beside the counter in the lab top level and in its bench.

---
 rtl/counter_monitor.sv | 168 ++++++++++++++++
 tb/tb_counter_monitor.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/counter_monitor.sv
// Receive-side checker for the T-flip-flop ripple counter: synchronises and
// debounces the rippling Q bits, then verifies every accepted change is +1.
module counter_monitor #(
  parameter int unsigned WIDTH         = 3,
  parameter int unsigned STABLE_CYCLES = 2,
  parameter int unsigned LOCK_COUNT    = 4,
  parameter int unsigned ERR_W         = 8
) (
  input  logic             sysclk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] q_in,
  input  logic             clr_err,
  output logic [WIDTH-1:0] count_val,
  output logic             step_valid,
  output logic             locked,
  output logic             wrap_pulse,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       state
);

  localparam int unsigned STAB_W = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned RUN_W  = $clog2(LOCK_COUNT + 1);

  localparam logic [1:0]        ST_ACQUIRE = 2'd0;
  localparam logic [1:0]        ST_LOCKED  = 2'd1;
  localparam logic [1:0]        ST_FAULT   = 2'd2;
  localparam logic [STAB_W-1:0] STAB_MAX   = STAB_W'(STABLE_CYCLES);
  localparam logic [RUN_W-1:0]  RUN_LOCK   = RUN_W'(LOCK_COUNT);
  localparam logic [ERR_W-1:0]  ERR_MAX    = '1;

  logic [WIDTH-1:0]  sync_q1;
  logic [WIDTH-1:0]  sync_val;
  logic [WIDTH-1:0]  cand;
  logic [STAB_W-1:0] stab;
  logic [STAB_W-1:0] stab_nxt;
  logic              accept_c;
  logic              good_c;
  logic              wrap_c;

  logic [1:0]        state_nxt;
  logic [RUN_W-1:0]  good_run;
  logic [RUN_W-1:0]  run_nxt;

  logic              locked_nxt;
  logic              wrap_nxt;
  logic              err_nxt;
  logic [ERR_W-1:0]  err_count_nxt;

  // Two-flop synchroniser per bit
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1  <= '0;
      sync_val <= '0;
    end else begin
      sync_q1  <= q_in;
      sync_val <= sync_q1;
    end
  end

  // Debounce run length; the candidate always follows sync_val
  always_comb begin
    stab_nxt = stab;
    if (sync_val != cand) begin
      stab_nxt = STAB_W'(1);
    end else if (stab != STAB_MAX) begin
      stab_nxt = stab + STAB_W'(1);
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      cand <= '0;
      stab <= '0;
    end else begin
      cand <= sync_val;
      stab <= stab_nxt;
    end
  end

  // Accept on the sample that completes the stable run
  assign accept_c = (stab_nxt == STAB_MAX) && (sync_val != count_val);
  assign good_c   = (sync_val == WIDTH'(count_val + WIDTH'(1)));
  assign wrap_c   = good_c && (sync_val == '0);

  // FSM state register
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_ACQUIRE;
      good_run <= '0;
    end else begin
      state    <= state_nxt;
      good_run <= run_nxt;
    end
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    run_nxt   = good_run;
    case (state)
      ST_ACQUIRE: begin
        if (accept_c) begin
          if (good_c) begin
            // good_run stays below LOCK_COUNT while acquiring, so no overflow
            run_nxt = good_run + RUN_W'(1);
            if (run_nxt >= RUN_LOCK) begin
              state_nxt = ST_LOCKED;
            end
          end else begin
            run_nxt = '0;
          end
        end
      end
      ST_LOCKED: begin
        if (accept_c && !good_c) begin
          run_nxt   = '0;
          state_nxt = ST_FAULT;
        end
      end
      ST_FAULT: begin
        if (accept_c && good_c) begin
          run_nxt   = RUN_W'(1);
          state_nxt = (RUN_LOCK == RUN_W'(1)) ? ST_LOCKED : ST_ACQUIRE;
        end
      end
      default: begin
        state_nxt = ST_ACQUIRE;
        run_nxt   = '0;
      end
    endcase
  end

  // FSM outputs, registered below alongside count_val
  always_comb begin
    locked_nxt    = (state_nxt == ST_LOCKED);
    wrap_nxt      = accept_c && wrap_c && (state_nxt == ST_LOCKED);
    err_nxt       = accept_c && !good_c &&
                    ((state == ST_LOCKED) || (state == ST_FAULT));
    err_count_nxt = err_count;
    if (clr_err) begin
      err_count_nxt = '0;
    end else if (err_nxt && (err_count != ERR_MAX)) begin
      err_count_nxt = err_count + ERR_W'(1);
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      count_val  <= '0;
      step_valid <= 1'b0;
      locked     <= 1'b0;
      wrap_pulse <= 1'b0;
      err_pulse  <= 1'b0;
      err_count  <= '0;
    end else begin
      if (accept_c) begin
        count_val <= sync_val;
      end
      step_valid <= accept_c;
      locked     <= locked_nxt;
      wrap_pulse <= wrap_nxt;
      err_pulse  <= err_nxt;
      err_count  <= err_count_nxt;
    end
  end

endmodule

// File: tb/tb_counter_monitor.sv
// Bench for counter_monitor: directed scenarios plus random stimulus, checked
// every cycle against a sample-history reference model.
module tb_counter_monitor;

  localparam int WIDTH  = 3;
  localparam int STABLE = 2;
  localparam int LOCKC  = 4;
  localparam int ERR_W  = 8;
  localparam int MODN   = 1 << WIDTH;
  localparam int ERRMAX = (1 << ERR_W) - 1;

  logic             sysclk  = 1'b0;
  logic             rst_n   = 1'b0;
  logic [WIDTH-1:0] q_in    = '0;
  logic             clr_err = 1'b0;
  logic [WIDTH-1:0] count_val;
  logic             step_valid;
  logic             locked;
  logic             wrap_pulse;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
  logic [1:0]       state;

  counter_monitor #(
    .WIDTH(WIDTH), .STABLE_CYCLES(STABLE), .LOCK_COUNT(LOCKC), .ERR_W(ERR_W)
  ) dut (
    .sysclk(sysclk), .rst_n(rst_n), .q_in(q_in), .clr_err(clr_err),
    .count_val(count_val), .step_valid(step_valid), .locked(locked),
    .wrap_pulse(wrap_pulse), .err_pulse(err_pulse), .err_count(err_count),
    .state(state)
  );

  always #5 sysclk = ~sysclk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: raw samples of q_in, the last STABLE synchronised values,
  // and the sequence checker expressed as plain integers.
  int m_raw1 = 0, m_raw2 = 0;
  int m_hist [STABLE];
  int m_count = 0, m_state = 0, m_run = 0, m_errc = 0;
  int m_step = 0, m_wrap = 0, m_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_raw1 = 0; m_raw2 = 0;
    for (int i = 0; i < STABLE; i++) m_hist[i] = 0;
    m_count = 0; m_state = 0; m_run = 0; m_errc = 0;
    m_step = 0; m_wrap = 0; m_err = 0;
  endtask

  always @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      int seen;
      bit all_eq;
      bit good;
      seen   = m_raw2;
      m_raw2 = m_raw1;
      m_raw1 = int'(q_in);
      for (int i = STABLE - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = seen;
      all_eq = 1'b1;
      for (int i = 1; i < STABLE; i++) if (m_hist[i] != m_hist[0]) all_eq = 1'b0;
      m_step = 0; m_wrap = 0; m_err = 0;
      if (all_eq && m_hist[0] != m_count) begin
        good   = (m_hist[0] == (m_count + 1) % MODN);
        m_step = 1;
        case (m_state)
          0: if (good) begin m_run++; if (m_run >= LOCKC) m_state = 1; end
             else m_run = 0;
          1: if (!good) begin m_err = 1; m_run = 0; m_state = 2; end
          default: if (good) begin m_run = 1; m_state = (LOCKC == 1) ? 1 : 0; end
                   else m_err = 1;
        endcase
        m_wrap  = (good && m_hist[0] == 0 && m_state == 1) ? 1 : 0;
        m_count = m_hist[0];
      end
      if (clr_err) m_errc = 0;
      else if (m_err != 0 && m_errc < ERRMAX) m_errc++;
    end
  end

  // Compare process: every output, every cycle, away from the active edge
  always @(negedge sysclk) begin
    check("count_val",  32'(count_val),  32'(m_count));
    check("step_valid", 32'(step_valid), 32'(m_step));
    check("locked",     32'(locked),     32'(m_state == 1));
    check("wrap_pulse", 32'(wrap_pulse), 32'(m_wrap));
    check("err_pulse",  32'(err_pulse),  32'(m_err));
    check("err_count",  32'(err_count),  32'(m_errc));
    check("state",      32'(state),      32'(m_state));
  end

  // Drive v and return on the negedge where its accept must be visible
  task automatic step_to(input int v);
    q_in = WIDTH'(v);
    repeat (3) @(negedge sysclk);
    check("lat_early", 32'(step_valid), 32'd0);
    @(negedge sysclk);
    check("lat_step", 32'(step_valid), 32'd1);
    check("lat_count", 32'(count_val), 32'(v));
  endtask

  task automatic settle();
    repeat (4) @(negedge sysclk);
  endtask

  initial begin
    int v;
    repeat (2) @(negedge sysclk);
    check("rst_count", 32'(count_val), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    rst_n = 1'b1;
    settle();

    // Acquire and lock on 1..4
    for (int i = 1; i <= 4; i++) begin step_to(i); settle(); end
    check("t1_locked", 32'(locked), 32'd1);
    check("t1_state", 32'(state), 32'd1);
    check("t1_errc", 32'(err_count), 32'd0);

    // Wrap while locked
    for (int i = 5; i <= 7; i++) begin step_to(i); settle(); end
    step_to(0);
    check("t2_wrap", 32'(wrap_pulse), 32'd1);
    check("t2_locked", 32'(locked), 32'd1);
    settle();

    // Fault and relock
    step_to(1); settle();
    step_to(2); settle();
    step_to(5);
    check("t3_err", 32'(err_pulse), 32'd1);
    check("t3_errc1", 32'(err_count), 32'd1);
    check("t3_state_f", 32'(state), 32'd2);
    settle();
    step_to(7);
    check("t3_errc2", 32'(err_count), 32'd2);
    settle();
    step_to(0);
    check("t3_state_a", 32'(state), 32'd0);
    settle();
    for (int i = 1; i <= 3; i++) begin step_to(i); settle(); end
    check("t3_relock", 32'(state), 32'd1);

    // One-cycle ripple glitch is ignored
    q_in = 3'd2;
    @(negedge sysclk);
    step_to(4);
    check("t4_noerr", 32'(err_pulse), 32'd0);
    check("t4_errc", 32'(err_count), 32'd2);
    settle();

    // Asynchronous reset while locked at 6
    step_to(5); settle();
    step_to(6); settle();
    check("t6_pre", 32'(locked), 32'd1);
    @(posedge sysclk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_count", 32'(count_val), 32'd0);
    check("t6_async_locked", 32'(locked), 32'd0);
    check("t6_async_errc", 32'(err_count), 32'd0);
    check("t6_async_state", 32'(state), 32'd0);
    repeat (2) @(negedge sysclk);
    rst_n = 1'b1;
    step_to(6);
    check("t6_locked", 32'(locked), 32'd0);
    check("t6_state", 32'(state), 32'd0);
    check("t6_errc", 32'(err_count), 32'd0);
    settle();

    // Error counter saturation and clear priority
    for (int i = 0; i < 4; i++) begin step_to((7 + i) % MODN); settle(); end
    check("t5_locked", 32'(locked), 32'd1);
    v = 2;
    for (int i = 0; i < ERRMAX; i++) begin
      v = (v + 2) % MODN;
      q_in = WIDTH'(v);
      settle();
    end
    check("t5_errc255", 32'(err_count), 32'd255);
    v = (v + 2) % MODN;
    q_in = WIDTH'(v);
    settle();
    check("t5_sat", 32'(err_count), 32'd255);
    v = (v + 2) % MODN;
    q_in = WIDTH'(v);
    repeat (3) @(negedge sysclk);
    clr_err = 1'b1;
    @(negedge sysclk);
    clr_err = 1'b0;
    check("t5_clr_pulse", 32'(err_pulse), 32'd1);
    check("t5_clr_errc", 32'(err_count), 32'd0);
    settle();

    // Randomised: mostly +1 steps, with glitches, jumps and clears
    for (int n = 0; n < 400; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 6) begin
        q_in = WIDTH'(int'(q_in) + 1);
      end else if (r == 6) begin
        q_in = WIDTH'($urandom_range(0, MODN - 1));
        @(negedge sysclk);
        q_in = WIDTH'(int'(q_in) + 1);
      end else begin
        q_in = WIDTH'($urandom_range(0, MODN - 1));
      end
      clr_err = ($urandom_range(0, 15) == 0);
      @(negedge sysclk);
      clr_err = 1'b0;
      repeat ($urandom_range(0, 5)) @(negedge sysclk);
    end
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
